bcd_counter2: RTL and testbench

Two-digit BCD up/down counter that drives the team's bcd7seg decoders. It counts 00..99 at a rate set by an internal prescaler, and supports enable, direction and parallel load. BCD1 (tens) and BCD0 (ones) connect directly to two bcd7seg instances driving HEX1/HEX0. Every output is always a legal BCD digit, 0..9.

---
 rtl/bcd_counter2.sv | 127 ++++++++++++
 tb/tb_bcd_counter2.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter2.sv
// Two-digit BCD up/down counter with prescaled step rate, enable and parallel load.
// Digits only ever hold 0..9, so they can feed bcd7seg decoders directly.
module bcd_counter2 #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned PRE_W    = 26
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       En,
   input  logic       Up,
   input  logic       Load,
   input  logic [3:0] D1,
   input  logic [3:0] D0,
   output logic [3:0] BCD1,
   output logic [3:0] BCD0,
   output logic       Tick,
   output logic       Wrap
);

   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       ones_q, ones_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic             step_s;

   function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
      if (v > 4'd9) begin
         return 4'd9;
      end else begin
         return v;
      end
   endfunction

   // Prescaler: restarts on load, freezes when disabled, flags a step on terminal count.
   always_comb begin
      pre_d  = pre_q;
      step_s = 1'b0;
      if (Load) begin
         pre_d = '0;
      end else if (En) begin
         if (pre_q == PRE_MAX) begin
            pre_d  = '0;
            step_s = 1'b1;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end else begin
         pre_d = pre_q;
      end
   end

   // Digit update, with Tick/Wrap computed so they appear alongside the new digits.
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      if (Load) begin
         tens_d = clamp_bcd(D1);
         ones_d = clamp_bcd(D0);
      end else if (step_s) begin
         tick_d = 1'b1;
         case (Up)
            1'b1: begin
               if (ones_q < 4'd9) begin
                  ones_d = ones_q + 4'd1;
               end else begin
                  ones_d = 4'd0;
                  if (tens_q < 4'd9) begin
                     tens_d = tens_q + 4'd1;
                  end else begin
                     tens_d = 4'd0;
                     wrap_d = 1'b1;
                  end
               end
            end
            1'b0: begin
               // Out-of-range codes are unreachable; treat them like 9 so they resolve legally.
               if (ones_q != 4'd0) begin
                  ones_d = clamp_bcd(ones_q) - 4'd1;
               end else begin
                  ones_d = 4'd9;
                  if (tens_q != 4'd0) begin
                     tens_d = clamp_bcd(tens_q) - 4'd1;
                  end else begin
                     tens_d = 4'd9;
                     wrap_d = 1'b1;
                  end
               end
            end
            default: begin
               tens_d = tens_q;
               ones_d = ones_q;
            end
         endcase
      end else begin
         tens_d = tens_q;
         ones_d = ones_q;
      end
   end

   // State and output registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pre_q  <= '0;
         tens_q <= 4'd0;
         ones_q <= 4'd0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tens_q <= tens_d;
         ones_q <= ones_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   assign BCD1 = tens_q;
   assign BCD0 = ones_q;
   assign Tick = tick_q;
   assign Wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter2.sv
// Scoreboard bench for bcd_counter2: two instances (TICK_DIV=4 and TICK_DIV=1) share stimulus
// and are compared every cycle against an integer 0..99 reference model.
module tb_bcd_counter2;

   localparam int TD_A = 4;
   localparam int TD_B = 1;

   typedef struct packed {
      logic [3:0] b1;
      logic [3:0] b0;
      logic       t;
      logic       w;
   } exp_t;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       En    = 1'b0;
   logic       Up    = 1'b1;
   logic       Load  = 1'b0;
   logic [3:0] D1    = 4'd0;
   logic [3:0] D0    = 4'd0;
   logic [3:0] a_bcd1, a_bcd0, b_bcd1, b_bcd0;
   logic       a_tick, a_wrap, b_tick, b_wrap;

   int   errors = 0;
   int   checks = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   int   m_val[2];
   int   m_pre[2];

   always #5 Clock = ~Clock;

   bcd_counter2 #(.TICK_DIV(TD_A), .PRE_W(3)) u_dut_a (
      .Clock(Clock), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .D1(D1), .D0(D0),
      .BCD1(a_bcd1), .BCD0(a_bcd0), .Tick(a_tick), .Wrap(a_wrap)
   );

   bcd_counter2 #(.TICK_DIV(TD_B), .PRE_W(1)) u_dut_b (
      .Clock(Clock), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .D1(D1), .D0(D0),
      .BCD1(b_bcd1), .BCD0(b_bcd0), .Tick(b_tick), .Wrap(b_wrap)
   );

   task automatic check_out(input string name, input exp_t e, input logic [3:0] b1,
                            input logic [3:0] b0, input logic t, input logic w);
      checks++;
      if (b1 !== e.b1 || b0 !== e.b0 || t !== e.t || w !== e.w) begin
         errors++;
         $display("FAIL %s @%0t: got bcd=%0d%0d tick=%0b wrap=%0b, expected bcd=%0d%0d tick=%0b wrap=%0b",
                  name, $time, b1, b0, t, w, e.b1, e.b0, e.t, e.w);
      end
   endtask

   // Reference model: the count is a plain integer 0..99 advanced modulo 100.
   task automatic model_step(input int k, input logic rst, input logic en, input logic up,
                             input logic ld, input logic [3:0] d1, input logic [3:0] d0,
                             output exp_t e);
      int td;
      int c1;
      int c0;
      td  = (k == 0) ? TD_A : TD_B;
      e.t = 1'b0;
      e.w = 1'b0;
      if (rst) begin
         m_val[k] = 0;
         m_pre[k] = 0;
      end else if (ld) begin
         c1 = (int'(d1) > 9) ? 9 : int'(d1);
         c0 = (int'(d0) > 9) ? 9 : int'(d0);
         m_val[k] = 10 * c1 + c0;
         m_pre[k] = 0;
      end else if (en) begin
         if (m_pre[k] == td - 1) begin
            m_pre[k] = 0;
            e.t = 1'b1;
            if (up) begin
               e.w = (m_val[k] == 99);
               m_val[k] = (m_val[k] + 1) % 100;
            end else begin
               e.w = (m_val[k] == 0);
               m_val[k] = (m_val[k] + 99) % 100;
            end
         end else begin
            m_pre[k] = m_pre[k] + 1;
         end
      end
      e.b1 = 4'(m_val[k] / 10);
      e.b0 = 4'(m_val[k] % 10);
   endtask

   task automatic cycle(input logic rst, input logic en, input logic up, input logic ld,
                        input logic [3:0] d1, input logic [3:0] d0);
      exp_t ea;
      exp_t eb;
      @(negedge Clock);
      Reset = rst; En = en; Up = up; Load = ld; D1 = d1; D0 = d0;
      model_step(0, rst, en, up, ld, d1, d0, ea);
      model_step(1, rst, en, up, ld, d1, d0, eb);
      q_a.push_back(ea);
      q_b.push_back(eb);
   endtask

   task automatic run(input int n, input logic en, input logic up);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, en, up, 1'b0, 4'd0, 4'd0);
      end
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock edge.
   task automatic async_reset();
      exp_t z;
      @(negedge Clock);
      Load = 1'b0;
      #2;
      Reset = 1'b1;
      #1;
      z = '0;
      check_out("async_reset_a", z, a_bcd1, a_bcd0, a_tick, a_wrap);
      check_out("async_reset_b", z, b_bcd1, b_bcd0, b_tick, b_wrap);
      model_step(0, 1'b1, En, Up, 1'b0, 4'd0, 4'd0, z);
      q_a.push_back(z);
      model_step(1, 1'b1, En, Up, 1'b0, 4'd0, 4'd0, z);
      q_b.push_back(z);
   endtask

   // Monitor: every cycle the registered outputs are presented; pop and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clock);
         #1;
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check_out("td4", e, a_bcd1, a_bcd0, a_tick, a_wrap);
         end
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check_out("td1", e, b_bcd1, b_bcd0, b_tick, b_wrap);
         end
      end
   end

   initial begin
      exp_t z;
      int   r;
      z = '0;
      #1;
      check_out("reset_a", z, a_bcd1, a_bcd0, a_tick, a_wrap);
      check_out("reset_b", z, b_bcd1, b_bcd0, b_tick, b_wrap);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);

      // Count up from 00
      run(16, 1'b1, 1'b1);
      // Up through 99 -> 00
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd8);
      run(12, 1'b1, 1'b1);
      // Down through 00 -> 99
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1);
      run(16, 1'b1, 1'b0);
      // Clamped load, then load on the edge where a step is due
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 4'd15);
      run(3, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd3);
      run(8, 1'b1, 1'b1);
      // Freeze mid-interval at pre=2
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
      run(2, 1'b1, 1'b1);
      run(10, 1'b0, 1'b1);
      run(4, 1'b1, 1'b1);
      // Async reset mid-interval while showing 57
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd7);
      run(2, 1'b1, 1'b1);
      async_reset();
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      run(9, 1'b1, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         cycle((r < 2) ? 1'b1 : 1'b0,
               ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
               ($urandom_range(0, 19) < 19) ? Up : ~Up,
               (r >= 95) ? 1'b1 : 1'b0,
               4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
      end
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9);
      run(8, 1'b1, 1'b1);

      for (int i = 0; i < 4 && (q_a.size() > 0 || q_b.size() > 0); i++) begin
         @(posedge Clock);
         #2;
      end
      if (q_a.size() > 0 || q_b.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d/%0d expectations left, required 0", q_a.size(), q_b.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
